i2c_cmd_seq: RTL and testbench

//  Command sequencer directly upstream of i2c_master; queues single-byte transactions and launches each one.

---
 rtl/i2c_cmd_seq_pkg.sv | 21 ++
 rtl/i2c_cmd_seq_fifo.sv | 50 +++++
 rtl/i2c_cmd_seq.sv | 159 +++++++++++++++
 tb/tb_i2c_cmd_seq.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_cmd_seq_pkg.sv
// Shared types for the I2C command sequencer: command/response words and FSM state encoding.
// Pure declarations, no logic.
package i2c_pkg;

    typedef struct packed {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] data;
    } cmd_t;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] err;
    } rsp_t;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} seq_state_e;

    localparam int ERR_NACK = 0;
    localparam int ERR_TMO  = 1;

endpackage

// File: rtl/i2c_cmd_seq_fifo.sv
// Show-ahead synchronous queue; a push is readable the cycle after it lands.
// Backpressure: o_wr_rdy drops when full and only rises after a pop has registered.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_vld,
    output logic             o_wr_rdy,
    input  logic [WIDTH-1:0] i_wr_dat,
    output logic             o_rd_vld,
    input  logic             i_rd_rdy,
    output logic [WIDTH-1:0] o_rd_dat
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wp;
    logic [AW:0]      r_rp;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign w_full   = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_empty  = (r_wp == r_rp);
    assign w_push   = i_wr_vld && !w_full;
    assign w_pop    = i_rd_rdy && !w_empty;
    assign o_wr_rdy = !w_full;
    assign o_rd_vld = !w_empty;
    assign o_rd_dat = r_mem[r_rp[AW-1:0]];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wp[AW-1:0]] <= i_wr_dat;
    end

endmodule

// File: rtl/i2c_cmd_seq.sv
// Queues single-byte I2C commands, launches them one at a time on i2c_master, returns one response each.
// cmd accept -> m_start in 2 cycles; busy fall -> rsp_valid in 2 cycles; launch stalls while the response queue is full.
import i2c_pkg::*;

module i2c_cmd_seq #(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int TIMEOUT   = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [1:0] rsp_err,
    output logic [6:0] m_addr,
    output logic       m_rw,
    output logic [7:0] m_data_w,
    output logic       m_start,
    input  logic [7:0] m_data_out,
    input  logic       m_valid_out,
    input  logic       m_busy,
    input  logic       m_erro_addr,
    output logic       idle
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_LAUNCH = LAUNCH;
    localparam logic [1:0] ST_WAIT   = WAIT;
    localparam logic [1:0] ST_RESP   = RESP;

    logic [1:0]    r_state;
    logic [6:0]    r_addr;
    logic          r_rw;
    logic [7:0]    r_data_w;
    logic          r_start;
    logic [TW-1:0] r_tmo;
    logic [7:0]    r_data;
    logic [1:0]    r_err;

    cmd_t w_cmd_in;
    cmd_t w_cmd_head;
    rsp_t w_rsp_in;
    rsp_t w_rsp_head;
    logic w_cmd_vld;
    logic w_rsp_rdy;
    logic w_launch;
    logic w_rsp_push;
    logic w_capture;
    logic w_tmo_hit;

    assign w_cmd_in   = {cmd_addr, cmd_rw, cmd_data};
    assign w_launch   = (r_state == ST_IDLE) && w_cmd_vld && w_rsp_rdy;
    assign w_rsp_push = (r_state == ST_RESP);
    assign w_tmo_hit  = (r_tmo == TW'(TIMEOUT - 1));
    // A master may strobe in the same cycle it raises busy, before the FSM has reached WAIT.
    assign w_capture  = (r_state == ST_WAIT) || ((r_state == ST_LAUNCH) && m_busy);

    always_comb begin
        w_rsp_in      = '0;
        w_rsp_in.err  = r_err;
        w_rsp_in.data = (r_rw && (r_err == 2'b00)) ? r_data : 8'h00;
    end

    sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_wr_vld (cmd_valid),
        .o_wr_rdy (cmd_ready),
        .i_wr_dat (w_cmd_in),
        .o_rd_vld (w_cmd_vld),
        .i_rd_rdy (w_launch),
        .o_rd_dat (w_cmd_head)
    );

    sync_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_wr_vld (w_rsp_push),
        .o_wr_rdy (w_rsp_rdy),
        .i_wr_dat (w_rsp_in),
        .o_rd_vld (rsp_valid),
        .i_rd_rdy (rsp_ready),
        .o_rd_dat (w_rsp_head)
    );

    assign rsp_data = w_rsp_head.data;
    assign rsp_err  = w_rsp_head.err;
    assign m_addr   = r_addr;
    assign m_rw     = r_rw;
    assign m_data_w = r_data_w;
    assign m_start  = r_start;
    assign idle     = (r_state == ST_IDLE) && !w_cmd_vld && !rsp_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_rw     <= 1'b0;
            r_data_w <= '0;
            r_start  <= 1'b0;
            r_tmo    <= '0;
            r_data   <= '0;
            r_err    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_addr   <= w_cmd_head.addr;
                        r_rw     <= w_cmd_head.rw;
                        r_data_w <= w_cmd_head.data;
                        r_start  <= 1'b1;
                        r_tmo    <= '0;
                        r_data   <= '0;
                        r_err    <= '0;
                        r_state  <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    if (m_busy) begin
                        r_start <= 1'b0;
                        r_tmo   <= '0;
                        r_state <= ST_WAIT;
                    end else if (w_tmo_hit) begin
                        r_start        <= 1'b0;
                        r_err[ERR_TMO] <= 1'b1;
                        r_state        <= ST_RESP;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                ST_WAIT: begin
                    if (!m_busy) begin
                        r_state <= ST_RESP;
                    end else if (w_tmo_hit) begin
                        r_err[ERR_TMO] <= 1'b1;
                        r_state        <= ST_RESP;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            // Last strobe wins; NACK is sticky for the rest of the transaction.
            if (w_capture) begin
                if (m_valid_out) r_data <= m_data_out;
                if (m_erro_addr) r_err[ERR_NACK] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2c_cmd_seq.sv
// Scoreboard bench: a behavioural i2c_master stand-in plays per-command waveforms; expected responses are derived from them.
`timescale 1ns/1ps
module tb_i2c_cmd_seq;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_rw;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic [1:0] rsp_err;
    logic [6:0] m_addr;
    logic       m_rw, m_start;
    logic [7:0] m_data_w, m_data_out;
    logic       m_valid_out, m_busy, m_erro_addr;
    logic       idle;

    always #5 clk = ~clk;

    i2c_cmd_seq #(.CMD_DEPTH(4), .RSP_DEPTH(4), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_rw(cmd_rw), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .m_addr(m_addr), .m_rw(m_rw), .m_data_w(m_data_w), .m_start(m_start),
        .m_data_out(m_data_out), .m_valid_out(m_valid_out), .m_busy(m_busy),
        .m_erro_addr(m_erro_addr), .idle(idle)
    );

    // One row per master cycle after launch is seen; tmo means the master never answers.
    typedef struct packed {
        logic         tmo;
        logic [6:0]   addr;
        logic         rw;
        logic [7:0]   wdat;
        logic [4:0]   len;
        logic [15:0]  busy;
        logic [15:0]  vo;
        logic [15:0]  ea;
        logic [127:0] dat;
    } plan_t;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] err;
    } exp_t;

    plan_t plans[$];
    exp_t  exps[$];
    int    n_chk = 0;
    int    n_fail = 0;
    int    launches = 0;
    bit    abort = 1'b0;
    bit    lat_chk = 1'b0;
    bit    rr_rand = 1'b0;
    bit    rr_val = 1'b1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic plan_t norm_plan(logic [6:0] a, logic rw, logic [7:0] wd, int d, int n);
        plan_t p = '0;
        p.addr = a; p.rw = rw; p.wdat = wd;
        p.len  = 5'(d + n + 1);
        for (int i = d; i < d + n; i++) p.busy[i] = 1'b1;
        return p;
    endfunction

    function automatic plan_t tmo_plan(logic [6:0] a, logic rw, logic [7:0] wd);
        plan_t p = '0;
        p.tmo = 1'b1; p.addr = a; p.rw = rw; p.wdat = wd;
        return p;
    endfunction

    function automatic plan_t rand_plan();
        plan_t p;
        int d, n;
        if ($urandom_range(0, 7) == 0)
            return tmo_plan(7'($urandom), 1'($urandom), 8'($urandom));
        d = $urandom_range(0, 5);
        n = $urandom_range(1, 6);
        p = norm_plan(7'($urandom), 1'($urandom), 8'($urandom), d, n);
        for (int i = d; i <= d + n; i++) begin
            p.vo[i]         = ($urandom_range(0, 3) == 0);
            p.ea[i]         = ($urandom_range(0, 9) == 0);
            p.dat[i*8 +: 8] = 8'($urandom);
        end
        return p;
    endfunction

    // Response rules: timeout -> err=10/0x00; NACK anywhere -> err=01/0x00; read -> last strobed byte; write -> 0x00.
    function automatic exp_t expect_of(plan_t p);
        exp_t       e;
        logic       nack = 1'b0;
        logic [7:0] last = 8'h00;
        if (p.tmo) begin
            e.data = 8'h00; e.err = 2'b10;
            return e;
        end
        for (int i = 0; i < int'(p.len); i++) begin
            if (p.vo[i]) last = p.dat[i*8 +: 8];
            if (p.ea[i]) nack = 1'b1;
        end
        e.err  = {1'b0, nack};
        e.data = (p.rw && !nack) ? last : 8'h00;
        return e;
    endfunction

    task automatic send(plan_t p);
        int wc = 0;
        plans.push_back(p);
        exps.push_back(expect_of(p));
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_addr = p.addr; cmd_rw = p.rw; cmd_data = p.wdat;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            wc++;
            if (wc > 3000) begin chk("cmd_accept_wait", 0, 1); break; end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain(int budget);
        int c = 0;
        while ((exps.size() != 0 || !idle) && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("drain_pending", exps.size(), 0);
        chk("drain_idle", idle, 1);
    endtask

    initial begin : rsp_ready_drv
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            rsp_ready = rr_rand ? ($urandom_range(0, 3) != 0) : rr_val;
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid && rsp_ready) begin
                if (exps.size() == 0) chk("rsp_unexpected", 1, 0);
                else begin
                    e = exps.pop_front();
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_err", rsp_err, e.err);
                end
            end
        end
    end

    plan_t mp;
    int    mcnt;
    initial begin : master
        m_busy = 1'b0; m_valid_out = 1'b0; m_erro_addr = 1'b0; m_data_out = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst && m_start) begin
                launches++;
                if (plans.size() == 0) chk("launch_unexpected", 1, 0);
                else begin
                    mp = plans.pop_front();
                    chk("m_addr", m_addr, mp.addr);
                    chk("m_rw", m_rw, mp.rw);
                    if (!mp.rw) chk("m_data_w", m_data_w, mp.wdat);
                    if (mp.tmo) begin
                        mcnt = 0;
                        while (m_start && mcnt < 100 && !abort) begin
                            mcnt++;
                            @(negedge clk);
                        end
                        if (!abort) chk("start_hold_cycles", mcnt, TMO);
                    end else begin
                        for (int i = 0; i < int'(mp.len); i++) begin
                            @(posedge clk); #1;
                            if (abort) break;
                            m_busy = mp.busy[i]; m_valid_out = mp.vo[i];
                            m_erro_addr = mp.ea[i]; m_data_out = mp.dat[i*8 +: 8];
                        end
                        @(posedge clk); #1;
                        m_busy = 1'b0; m_valid_out = 1'b0; m_erro_addr = 1'b0; m_data_out = 8'h00;
                        if (lat_chk && !abort) begin
                            @(negedge clk); chk("rsp_lat_cyc1", rsp_valid, 0);
                            @(negedge clk); chk("rsp_lat_cyc2", rsp_valid, 1);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        plan_t p;
        int    l0, wc;
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_rw = 1'b0; cmd_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_start", m_start, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_rw", m_rw, 0);
        chk("rst_m_data_w", m_data_w, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_idle", idle, 1);
        @(posedge clk); #1 rst = 1'b0;

        // Write with ACK, checking launch latency.
        lat_chk = 1'b1;
        p = norm_plan(7'h59, 1'b0, 8'hA5, 1, 3);
        plans.push_back(p); exps.push_back(expect_of(p));
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_addr = p.addr; cmd_rw = p.rw; cmd_data = p.wdat;
        @(negedge clk); chk("t1_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(negedge clk); chk("t1_start_early", m_start, 0);
        @(negedge clk); chk("t1_start_lat", m_start, 1);
        drain(200);

        // Read: two strobes, the second coincides with busy fall and must win.
        p = norm_plan(7'h59, 1'b1, 8'h00, 1, 4);
        p.vo[2] = 1'b1; p.dat[2*8 +: 8] = 8'h11;
        p.vo[5] = 1'b1; p.dat[5*8 +: 8] = 8'hB5;
        send(p);
        drain(200);
        lat_chk = 1'b0;

        // NACK on the busy-fall cycle, with a write queued behind it.
        p = norm_plan(7'h22, 1'b1, 8'h00, 0, 3);
        p.ea[3] = 1'b1; p.vo[2] = 1'b1; p.dat[2*8 +: 8] = 8'h77;
        send(p);
        send(norm_plan(7'h23, 1'b0, 8'h3C, 2, 2));
        drain(300);

        // Master never raises busy.
        send(tmo_plan(7'h10, 1'b0, 8'h55));
        drain(300);

        // Response queue backpressure.
        rr_val = 1'b0;
        l0 = launches;
        for (int i = 0; i < 5; i++) send(norm_plan(7'(8'h30 + i), 1'b1, 8'h00, 1, 1));
        repeat (150) @(negedge clk);
        chk("full_launches", launches - l0, 4);
        chk("full_rsp_valid", rsp_valid, 1);
        chk("full_start_held", m_start, 0);
        for (int i = 0; i < 3; i++) send(norm_plan(7'(8'h40 + i), 1'b0, 8'(i), 0, 2));
        @(negedge clk);
        chk("cmdq_full_ready", cmd_ready, 0);
        chk("cmdq_full_idle", idle, 0);
        rr_val = 1'b1;
        drain(2000);

        // Reset while the master is busy.
        p = norm_plan(7'h5A, 1'b0, 8'hC3, 0, 12);
        send(p);
        wc = 0;
        while (!m_busy && wc < 100) begin @(negedge clk); wc++; end
        chk("rst_txn_busy_seen", m_busy, 1);
        repeat (3) @(negedge clk);
        #2;
        abort = 1'b1;
        rst = 1'b1;
        #1;
        chk("midrst_m_start", m_start, 0);
        chk("midrst_m_addr", m_addr, 0);
        chk("midrst_m_data_w", m_data_w, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_idle", idle, 1);
        if (exps.size() != 0) void'(exps.pop_back());
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        abort = 1'b0;
        send(norm_plan(7'h5B, 1'b1, 8'h00, 1, 2));
        drain(200);

        // Randomized traffic with a random response consumer.
        rr_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(rand_plan());
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        drain(5000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
